uart_txrx_core: RTL and testbench

Byte-level UART engine sitting directly downstream of the APB UART register block: it accepts one command at a time over the cmd handshake, and each command either serialises one byte onto `tx` or captures one byte from `rx`. Completion is signalled by `cmd_rdy` rising, plus a `read_vld` pulse for receives. Frame format is fixed 8N1, LSB first, at a parameterised integer clock divider.

---
 rtl/uart_txrx_core.sv | 139 +++++++++++++
 tb/tb_uart_txrx_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txrx_core.sv
// Byte-level 8N1 UART engine: one command at a time, either shifts a byte out on tx
// or captures one byte from rx. A single bit timer serves both FSMs since they never overlap.
module uart_txrx_core #(
  parameter int CLK_DIV = 434
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic [15:0] cmd_in,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  output logic [7:0]  read_data,
  output logic        read_vld,
  output logic        frame_err,
  input  logic        rx,
  output logic        tx
);
  localparam logic [15:0] BIT_END  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(CLK_DIV / 2 - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_WAIT  = 3'd1;
  localparam logic [2:0] RX_CHECK = 3'd2;
  localparam logic [2:0] RX_DATA  = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;

  logic [1:0]  tx_state;
  logic [2:0]  rx_state;
  logic [15:0] bit_tmr;
  logic [7:0]  tx_shreg, rx_shreg;
  logic [2:0]  tx_bit, rx_bit;
  logic        rx_s1, rx_s2, rx_s3;

  logic accept, tx_go, rx_go, bit_end, rx_det, chk_tick, tmr_clr;
  logic unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_in[15:9];

  assign cmd_rdy  = (tx_state == TX_IDLE) && (rx_state == RX_IDLE);
  assign accept   = cmd_vld & cmd_rdy;
  assign tx_go    = accept & cmd_in[8];
  assign rx_go    = accept & ~cmd_in[8];
  assign bit_end  = (bit_tmr == BIT_END);
  assign rx_det   = (rx_state == RX_WAIT) && rx_s3 && !rx_s2;
  assign chk_tick = (rx_state == RX_CHECK) && (bit_tmr == HALF_END);

  // Timer restarts on every state (or bit) entry; held at zero while idle.
  assign tmr_clr = cmd_rdy
                 || ((tx_state != TX_IDLE) && bit_end)
                 || (((rx_state == RX_DATA) || (rx_state == RX_STOP)) && bit_end)
                 || chk_tick || rx_det;

  always_ff @(posedge pclk) begin
    if (prst || tmr_clr) bit_tmr <= '0;
    else                 bit_tmr <= bit_tmr + 16'd1;
  end

  always_ff @(posedge pclk) begin
    if (prst) {rx_s3, rx_s2, rx_s1} <= 3'b111;
    else      {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rx};
  end

  // tx is registered so the pin never glitches on state decode.
  always_ff @(posedge pclk) begin
    if (prst) begin
      tx_state <= TX_IDLE;
      tx_shreg <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_go) begin
          tx_state <= TX_START;
          tx_shreg <= cmd_in[7:0];
          tx_bit   <= '0;
          tx       <= 1'b0;
        end
        TX_START: if (bit_end) begin
          tx_state <= TX_DATA;
          tx       <= tx_shreg[0];
        end
        TX_DATA: if (bit_end) begin
          tx_shreg <= {1'b0, tx_shreg[7:1]};
          tx_bit   <= tx_bit + 3'd1;
          if (tx_bit == 3'd7) begin
            tx_state <= TX_STOP;
            tx       <= 1'b1;
          end else begin
            tx       <= tx_shreg[1];
          end
        end
        TX_STOP: if (bit_end) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      rx_state  <= RX_IDLE;
      rx_shreg  <= '0;
      rx_bit    <= '0;
      read_data <= '0;
      read_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      read_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE:  if (rx_go) rx_state <= RX_WAIT;
        RX_WAIT:  if (rx_det) rx_state <= RX_CHECK;
        // Mid-start resample: a high line means the edge was a glitch.
        RX_CHECK: if (chk_tick) begin
          rx_state <= rx_s2 ? RX_WAIT : RX_DATA;
          rx_bit   <= '0;
        end
        RX_DATA: if (bit_end) begin
          rx_shreg <= {rx_s2, rx_shreg[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end
        RX_STOP: if (bit_end) begin
          rx_state <= RX_IDLE;
          if (rx_s2) begin
            read_data <= rx_shreg;
            read_vld  <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_txrx_core.sv
// Scoreboard bench for uart_txrx_core: stimulus queues expected tx frames and rx events,
// independent monitors compare whenever the DUT produces them.
module tb_uart_txrx_core;
  localparam int D  = 8;
  localparam int FW = 10 * D;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic [15:0] cmd_in = '0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [7:0]  read_data;
  logic        read_vld;
  logic        frame_err;
  logic        rx = 1'b1;
  logic        tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  bit         rx_kind_q[$];
  logic [7:0] rx_data_q[$];
  logic [7:0] last_good = 8'h00;
  int         flush_req = 0;

  uart_txrx_core #(.CLK_DIV(D)) dut (
    .pclk(pclk), .prst(prst), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .read_data(read_data), .read_vld(read_vld), .frame_err(frame_err), .rx(rx), .tx(tx)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ideal line waveform of one frame, one sample per clock.
  function automatic logic [FW-1:0] tx_wave(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < FW; i++) tx_wave[i] = f[i / D];
  endfunction

  initial begin : tx_mon
    bit capturing = 0;
    int idx = 0;
    int flush_ack = 0;
    logic [FW-1:0] cap = '0;
    forever begin
      @(negedge pclk);
      if (flush_ack != flush_req) begin
        flush_ack = flush_req;
        capturing = 0;
      end else if (!capturing) begin
        if (tx === 1'b0) begin
          capturing = 1;
          cap = '0;
          cap[0] = 1'b0;
          idx = 1;
        end
      end else begin
        cap[idx] = tx;
        idx++;
        if (idx == FW) begin
          capturing = 0;
          if (tx_q.size() == 0) chk("tx_unexpected_frame", cap, {FW{1'b1}});
          else chk("tx_frame", cap, tx_wave(tx_q.pop_front()));
        end
      end
    end
  end

  initial begin : rx_mon
    logic prev_vld = 1'b0, prev_err = 1'b0;
    forever begin
      @(negedge pclk);
      if (read_vld && frame_err) chk("vld_err_overlap", 80'(2'b11), 80'(2'b00));
      if (prev_vld && read_vld) chk("read_vld_width", 80'(2), 80'(1));
      if (prev_err && frame_err) chk("frame_err_width", 80'(2), 80'(1));
      if (read_vld || frame_err) begin
        if (rx_kind_q.size() == 0) begin
          chk("rx_unexpected_event", 80'({read_vld, frame_err}), 80'(0));
        end else begin
          chk("rx_kind_err", 80'(frame_err), 80'(rx_kind_q.pop_front()));
          chk("rx_data", 80'(read_data), 80'(rx_data_q.pop_front()));
          chk("rx_done_rdy", 80'(cmd_rdy), 80'(1));
        end
      end
      prev_vld = read_vld;
      prev_err = frame_err;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_rdy(input string name);
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 2000) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 2000) chk({name, "_timeout"}, 80'(cmd_rdy), 80'(1));
  endtask

  task automatic issue(input logic [15:0] c);
    @(negedge pclk);
    cmd_in = c;
    cmd_vld = 1'b1;
    @(negedge pclk);
    cmd_vld = 1'b0;
  endtask

  task automatic do_tx(input logic [7:0] b, input string name);
    int n = 0;
    wait_rdy(name);
    tx_q.push_back(b);
    issue({7'($urandom), 1'b1, b});
    while (cmd_rdy === 1'b0 && n < 2000) begin
      n++;
      @(negedge pclk);
    end
    chk({name, "_busy_cycles"}, 80'(n), 80'(FW));
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (D) @(negedge pclk);
    end
    rx = 1'b1;
  endtask

  task automatic do_rx(input logic [7:0] b, input logic stop, input int gap, input string name);
    wait_rdy(name);
    if (stop) begin
      rx_kind_q.push_back(1'b0);
      rx_data_q.push_back(b);
      last_good = b;
    end else begin
      rx_kind_q.push_back(1'b1);
      rx_data_q.push_back(last_good);
    end
    issue({7'($urandom), 1'b0, 8'($urandom)});
    repeat (gap) @(negedge pclk);
    send_rx(b, stop);
    wait_rdy(name);
  endtask

  initial begin : stim
    int bad;
    logic [7:0] b;
    repeat (3) @(negedge pclk);
    prst = 1'b0;
    @(negedge pclk);
    chk("rst_tx", 80'(tx), 80'(1));
    chk("rst_cmd_rdy", 80'(cmd_rdy), 80'(1));
    chk("rst_read_vld", 80'(read_vld), 80'(0));
    chk("rst_frame_err", 80'(frame_err), 80'(0));
    chk("rst_read_data", 80'(read_data), 80'(0));

    do_tx(8'hA5, "tx_a5");
    do_rx(8'h3C, 1'b1, 3, "rx_3c");

    // Short low glitch while waiting for a start bit, then a real frame.
    wait_rdy("glitch");
    rx_kind_q.push_back(1'b0);
    rx_data_q.push_back(8'h81);
    last_good = 8'h81;
    issue(16'h0000);
    repeat (4) @(negedge pclk);
    rx = 1'b0;
    repeat (2) @(negedge pclk);
    rx = 1'b1;
    repeat (10) @(negedge pclk);
    send_rx(8'h81, 1'b1);
    wait_rdy("glitch");

    do_rx(8'h55, 1'b0, 2, "rx_ferr");

    // Busy collision: held cmd_vld is ignored until the current frame completes.
    wait_rdy("collide");
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'h00);
    issue(16'h01FF);
    repeat (20) @(negedge pclk);
    cmd_in = 16'h0100;
    cmd_vld = 1'b1;
    wait_rdy("collide");
    @(negedge pclk);
    cmd_vld = 1'b0;
    chk("collide_accept", 80'(cmd_rdy), 80'(0));
    wait_rdy("collide2");

    // Reset in the middle of data bit 3.
    wait_rdy("rst_mid");
    issue(16'h01C3);
    repeat (35) @(negedge pclk);
    flush_req++;
    prst = 1'b1;
    @(negedge pclk);
    prst = 1'b0;
    chk("rst_mid_tx", 80'(tx), 80'(1));
    chk("rst_mid_cmd_rdy", 80'(cmd_rdy), 80'(1));
    do_tx(8'h12, "tx_after_rst");

    // Line noise with no receive pending.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      rx = 1'($urandom);
      @(negedge pclk);
      if (cmd_rdy !== 1'b1) bad++;
    end
    rx = 1'b1;
    repeat (5) @(negedge pclk);
    chk("idle_noise_rdy_drops", 80'(bad), 80'(0));

    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom);
      if ($urandom_range(1, 0) == 1) do_tx(b, "rand_tx");
      else do_rx(b, ($urandom_range(4, 0) != 0), $urandom_range(20, 0), "rand_rx");
    end

    wait_rdy("final");
    repeat (2 * D) @(negedge pclk);
    chk("tx_q_drained", 80'(tx_q.size()), 80'(0));
    chk("rx_q_drained", 80'(rx_kind_q.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
